if_fetch_ctrl: RTL

- Instruction-fetch stage controller for the five-stage MIPS pipeline.
- Owns the PC register and issues fetches to instruction memory over a req / addr_ok / data_ok handshake.
- Buffers one fetched instruction for the decode stage.
- Consumes redirects from the write-back stage (exc_bus, for exceptions and eret) and from decode (jbr_bus, for branches). Discards stale in-flight fetches after a redirect.
- Flags misaligned PCs, which travel down the pipe and arrive at write-back as the fetch_error exception.

---
 rtl/if_fetch_ctrl_pkg.sv | 28 ++
 rtl/if_fetch_ctrl_if.sv | 18 +
 rtl/if_fetch_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants, state encoding and bus layouts for the instruction-fetch controller.
package if_fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC       = 32'hBFC0_0000;
    localparam logic [31:0] EXC_ENTER_ADDR = 32'hBFC0_0380;

    localparam int IF_ID_W = 65;
    localparam int JBR_W   = 33;
    localparam int EXC_W   = 33;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        fetch_error;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } redir_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response handshake between fetch (master) and memory (slave).
interface if_fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF stage: owns the PC, keeps one fetch outstanding, buffers one instruction for decode
// and squashes in-flight fetches after exception/branch redirects.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = if_fetch_ctrl_pkg::RESET_PC
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic [if_fetch_ctrl_pkg::EXC_W-1:0]   exc_bus,
    input  logic [if_fetch_ctrl_pkg::JBR_W-1:0]   jbr_bus,
    input  logic                                 id_allow_in,
    if_fetch_ctrl_if.master                      imem,
    output logic                                 IF_over,
    output logic [if_fetch_ctrl_pkg::IF_ID_W-1:0] IF_ID_bus,
    output logic [31:0]                          IF_pc
);
    import if_fetch_ctrl_pkg::*;

    fetch_state_t state_r, state_nx;
    logic [31:0]  pc_r, pc_nx;
    logic         drop_r, drop_nx;
    if_id_t       buf_r, buf_nx;

    redir_t       exc, jbr;
    logic         redir, misaligned, req_fire;
    logic [31:0]  target;

    assign exc        = exc_bus;
    assign jbr        = jbr_bus;
    assign redir      = exc.valid | jbr.valid;
    assign target     = exc.valid ? exc.pc : jbr.pc;
    assign misaligned = pc_r[1:0] != 2'b00;
    assign req_fire   = imem.inst_req & imem.inst_addr_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_REQ;
            pc_r    <= RESET_PC;
            drop_r  <= 1'b0;
            buf_r   <= '0;
        end else begin
            state_r <= state_nx;
            pc_r    <= pc_nx;
            drop_r  <= drop_nx;
            buf_r   <= buf_nx;
        end
    end

    always_comb begin
        state_nx = state_r;
        pc_nx    = pc_r;
        drop_nx  = drop_r;
        buf_nx   = buf_r;
        unique case (state_r)
            S_REQ: begin
                if (redir) begin
                    pc_nx = target;
                    // An accepted request still owes us data; wait it out and discard it.
                    if (req_fire) begin
                        state_nx = S_WAIT;
                        drop_nx  = 1'b1;
                    end
                end else if (misaligned) begin
                    buf_nx   = {1'b1, pc_r, 32'd0};
                    state_nx = S_HOLD;
                end else if (req_fire) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.inst_data_ok) begin
                    drop_nx = 1'b0;
                    if (redir) begin
                        pc_nx    = target;
                        state_nx = S_REQ;
                    end else if (drop_r) begin
                        state_nx = S_REQ;
                    end else begin
                        buf_nx   = {1'b0, pc_r, imem.inst_rdata};
                        state_nx = S_HOLD;
                    end
                end else if (redir) begin
                    // Stay here so only one request is ever in flight.
                    pc_nx   = target;
                    drop_nx = 1'b1;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_nx    = target;
                    state_nx = S_REQ;
                end else if (id_allow_in) begin
                    pc_nx    = pc_r + 32'd4;
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_REQ;
        endcase
    end

    assign imem.inst_req  = resetn & (state_r == S_REQ) & ~misaligned;
    assign imem.inst_addr = pc_r;
    assign IF_over        = state_r == S_HOLD;
    assign IF_ID_bus      = buf_r;
    assign IF_pc          = pc_r;

endmodule
